operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-side operand fetch unit for the napalm MIPS pipeline; it is the initiator of the general-purpose register file's two read ports. Accepts a decoded instruction's source register numbers and drives `ra1`/`ra2`. Combines the register file's `rd1`/`rd2` with forwarding from the EX and MEM stages and stalls on load-use hazards. Registers the resolved operands into the ID/EX pipeline register behind a valid/ready handshake.

## Interface
- `DATA_W`, 32: operand width.
- `REG_W`, 5: register-number width. Register 0 is hardwired to zero.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: a decoded instruction is present.
- `in_ready` out 1: the instruction is accepted this cycle.
- `in_pc` in 32: PC of the instruction.
- `in_rs`, `in_rt` in REG_W: source register numbers.
- `in_use_rs`, `in_use_rt` in 1: the source is actually read.
- `ra1`, `ra2` out REG_W: register-file read addresses. Combinational; `ra1 = in_rs`, `ra2 = in_rt`.
- `rd1`, `rd2` in DATA_W: register-file read data. Combinational; returns 0 for register 0.
- `ex_we`, `ex_is_load` in 1: the EX-stage instruction writes a register, and that instruction is a load.
- `ex_wa` in REG_W, `ex_wd` in DATA_W: EX destination register and ALU result.
- `mem_we` in 1, `mem_wa` in REG_W, `mem_wd` in DATA_W: MEM-stage write-back candidate.
- `flush` in 1: kill the ID/EX contents and any instruction offered this cycle.
- `out_valid` out 1, `out_ready` in 1: ID/EX handshake.
- `out_pc` out 32, `out_a`, `out_b` out DATA_W, `out_rs`, `out_rt` out REG_W: registered operands.
- `stall_cnt` out 32: saturating count of hazard-stall cycles.

## Operation
- **Match definition.** A source "matches" a stage when all of the following hold:
  - `use` is set for that source;
  - the register number is nonzero;
  - the stage's `we` is set;
  - the stage's `wa` equals the register number.
- **WB stage.** No WB check is needed. The register file writes on the falling edge, so WB data is already visible through `rd1`/`rd2` in the same cycle.
- **Hazard (`haz`).**
  - With forwarding: any source matches EX while `ex_is_load` is set.
  - Without forwarding: any source matches EX or MEM.
- **Operand select, per source.**
  1. EX match and not a load: use `ex_wd`.
  2. Otherwise MEM match: use `mem_wd`.
  3. Otherwise: use `rd`.
  - EX beats MEM when both match. Unused sources still pass `rd` through.
- **Handshake.**
  - `in_ready = !haz && !flush && (!out_valid || out_ready)`.
  - Accept is `in_valid && in_ready`. On accept, load all `out_*` and set `out_valid`.
  - Else, if `out_ready`, clear `out_valid`.
  - Else, hold all outputs stable.
- **Flush.** Clears `out_valid` next edge regardless of `out_ready`. Nothing is accepted in the flush cycle. Data registers may hold stale values.
- **Stall counter.** `stall_cnt` increments each cycle `in_valid && haz && !flush`. It saturates at 0xFFFF_FFFF.

## Timing
- Read-address path (`in_rs` to `ra1`) and the hazard/`in_ready` path are combinational, same cycle.
- Operand latency is 1 cycle: an instruction accepted at edge N has `out_valid=1` after edge N.
- A load-use hazard costs exactly 1 stall cycle under forwarding, because the load moves from EX to MEM. The stalled source then forwards `mem_wd`.
- Back-to-back throughput is 1 per cycle while `out_ready=1` and there is no hazard.
- **Reset:** `out_valid=0`, `out_pc=0`, `out_a=0`, `out_b=0`, `out_rs=0`, `out_rt=0`, `stall_cnt=0`; `in_ready` follows its equation (1 if no hazard).
- Reset asserted mid-operation discards the ID/EX contents at the next edge.
- `rst` has priority over `flush`, and `flush` has priority over accept.

## Configuration
- Macro `OPERAND_FORWARD_EN`.
- **Defined:** EX/MEM forwarding as above. Only load-use stalls.
- **Undefined:**
  - Operands always come from `rd1`/`rd2`.
  - Any EX or MEM match stalls until the producer reaches WB.
  - Forwarding muxes are removed, and the `ex_wd`/`mem_wd` inputs are ignored.

## Structure
- Shared package `napalm_pkg` holds:
  - `REG_W`, `DATA_W`;
  - `ZERO_REG = 5'd0`;
  - `typedef idex_op_t` for the `out_*` bundle.
- One natural sub-module, `fwd_select`. It takes one source register plus the EX/MEM buses and returns `data` and `haz`. `operand_fetch` instantiates it twice, for rs and rt.

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid=1`. Required: `out_valid=0`, `stall_cnt=0`. After release, first accept yields `out_valid=1` one edge later.
- **EX/MEM priority:** `in_rs=3`, `ex_wa=3`, `ex_we=1`, `ex_is_load=0`, `ex_wd=0x11`, `mem_wa=3`, `mem_we=1`, `mem_wd=0x22`. Required: `out_a=0x11`. Undefined macro: 2 stall cycles, then `out_a=rd1`.
- **Load-use:** `in_rt=5`, `ex_wa=5`, `ex_is_load=1`. Required: `in_ready=0` for 1 cycle and `stall_cnt=1`. Next cycle `mem_wa=5`, `mem_wd=0xCAFE` gives `out_b=0xCAFE`.
- **Zero register:** `in_rs=0`, `ex_wa=0`, `ex_we=1`, `ex_wd=0x55`. Required: no stall, `out_a=0`.
- **Backpressure:** `out_ready=0` with `out_valid=1`. Required: `in_ready=0`, outputs stable 4 cycles. Raising `out_ready` accepts the pending instruction the same cycle.
- **Flush:** `flush=1` with `in_valid=1` and `out_valid=1`. Required: `in_ready=0`, `out_valid=0` next edge, and the offered PC never appears on `out_pc`.

Source files
------------

// File: rtl/napalm_pkg.sv
// Shared widths and the ID/EX operand bundle for the napalm pipeline.
package napalm_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [31:0]       pc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
    } idex_op_t;

endpackage

// File: rtl/fwd_select.sv
// Per-source operand select and hazard detect against EX/MEM producers.
// OPERAND_FORWARD_EN enables EX/MEM bypass; otherwise any match stalls.
module fwd_select
    import napalm_pkg::*;
(
    input  logic              use_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [DATA_W-1:0] rd_i,
    input  logic              ex_we_i,
    input  logic              ex_is_load_i,
    input  logic [REG_W-1:0]  ex_wa_i,
    input  logic [DATA_W-1:0] ex_wd_i,
    input  logic              mem_we_i,
    input  logic [REG_W-1:0]  mem_wa_i,
    input  logic [DATA_W-1:0] mem_wd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              haz_o
);

    logic live;
    logic ex_hit;
    logic mem_hit;

    assign live    = use_i && (rs_i != ZERO_REG);
    assign ex_hit  = live && ex_we_i && (ex_wa_i == rs_i);
    assign mem_hit = live && mem_we_i && (mem_wa_i == rs_i);

`ifdef OPERAND_FORWARD_EN
    // A load in EX has no data yet; it forwards from MEM a cycle later.
    assign haz_o = ex_hit && ex_is_load_i;

    always_comb begin
        data_o = rd_i;
        unique case (1'b1)
            ex_hit && !ex_is_load_i: data_o = ex_wd_i;
            mem_hit:                 data_o = mem_wd_i;
            default:                 data_o = rd_i;
        endcase
    end
`else
    logic unused_ok;

    assign unused_ok = ^{ex_wd_i, mem_wd_i, ex_is_load_i};
    assign haz_o     = ex_hit || mem_hit;
    assign data_o    = rd_i;
`endif

endmodule

// File: rtl/operand_fetch.sv
// ID-stage operand fetch: register-file read, forwarding, load-use stall.
// Build option OPERAND_FORWARD_EN selects EX/MEM forwarding.
module operand_fetch
    import napalm_pkg::*;
#(
    parameter int DATA_W = napalm_pkg::DATA_W,
    parameter int REG_W  = napalm_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    output logic [REG_W-1:0]  ra1,
    output logic [REG_W-1:0]  ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_wa,
    input  logic [DATA_W-1:0] ex_wd,
    input  logic              mem_we,
    input  logic [REG_W-1:0]  mem_wa,
    input  logic [DATA_W-1:0] mem_wd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [31:0]       stall_cnt
);

    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              haz_a;
    logic              haz_b;
    logic              haz;
    logic              accept;

    idex_op_t    idex_q, idex_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;

    assign ra1 = in_rs;
    assign ra2 = in_rt;

    fwd_select u_fwd_rs (
        .use_i        (in_use_rs),
        .rs_i         (in_rs),
        .rd_i         (rd1),
        .ex_we_i      (ex_we),
        .ex_is_load_i (ex_is_load),
        .ex_wa_i      (ex_wa),
        .ex_wd_i      (ex_wd),
        .mem_we_i     (mem_we),
        .mem_wa_i     (mem_wa),
        .mem_wd_i     (mem_wd),
        .data_o       (a_sel),
        .haz_o        (haz_a)
    );

    fwd_select u_fwd_rt (
        .use_i        (in_use_rt),
        .rs_i         (in_rt),
        .rd_i         (rd2),
        .ex_we_i      (ex_we),
        .ex_is_load_i (ex_is_load),
        .ex_wa_i      (ex_wa),
        .ex_wd_i      (ex_wd),
        .mem_we_i     (mem_we),
        .mem_wa_i     (mem_wa),
        .mem_wd_i     (mem_wd),
        .data_o       (b_sel),
        .haz_o        (haz_b)
    );

    assign haz      = haz_a || haz_b;
    assign in_ready = !haz && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        idex_d  = idex_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            idex_d.pc = in_pc;
            idex_d.a  = a_sel;
            idex_d.b  = b_sel;
            idex_d.rs = in_rs;
            idex_d.rt = in_rt;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (in_valid && haz && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = idex_q.pc;
    assign out_a     = idex_q.a;
    assign out_b     = idex_q.b;
    assign out_rs    = idex_q.rs;
    assign out_rt    = idex_q.rt;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; expectations follow OPERAND_FORWARD_EN.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs, in_rt;
    logic        in_use_rs, in_use_rt;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        ex_we, ex_is_load;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wd;
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_a, out_b;
    logic [4:0]  out_rs, out_rt;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int stall_exp = 0;

    always #5 clk = ~clk;

    // Register file model: r0 reads zero, rN reads 0x1000+N.
    always_comb rd1 = (ra1 == 5'd0) ? 32'd0 : 32'h1000 + 32'(ra1);
    always_comb rd2 = (ra2 == 5'd0) ? 32'd0 : 32'h1000 + 32'(ra2);

    operand_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_use_rs  (in_use_rs),
        .in_use_rt  (in_use_rt),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_wa      (ex_wa),
        .ex_wd      (ex_wd),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs,
                         input logic [4:0] rt);
        in_valid = 1'b1;
        in_pc    = pc;
        in_rs    = rs;
        in_rt    = rt;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_pc = 32'h100;
        in_rs = 5'd1;
        in_rt = 5'd2;
        in_use_rs = 1'b1;
        in_use_rt = 1'b1;
        ex_we = 1'b0;
        ex_is_load = 1'b0;
        ex_wa = 5'd0;
        ex_wd = 32'd0;
        mem_we = 1'b0;
        mem_wa = 5'd0;
        mem_wd = 32'd0;
        flush = 1'b0;
        out_ready = 1'b1;

        // Reset held two cycles with a valid offer.
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // First accept after release.
        rst = 1'b0;
        offer(32'h100, 5'd1, 5'd2);
        chk("ra1", 32'(ra1), 32'd1);
        chk("ra2", 32'(ra2), 32'd2);
        tick();
        chk("acc_valid", 32'(out_valid), 32'd1);
        chk("acc_pc", out_pc, 32'h100);
        chk("acc_a", out_a, 32'h1001);
        chk("acc_b", out_b, 32'h1002);

        // EX and MEM both produce r3.
        offer(32'h104, 5'd3, 5'd2);
        ex_we = 1'b1; ex_wa = 5'd3; ex_wd = 32'h11;
        mem_we = 1'b1; mem_wa = 5'd3; mem_wd = 32'h22;
        #1;
`ifdef OPERAND_FORWARD_EN
        chk("prio_ready", 32'(in_ready), 32'd1);
        tick();
        chk("prio_a", out_a, 32'h11);
`else
        chk("prio_ready", 32'(in_ready), 32'd0);
        tick();
        stall_exp = 1;
        chk("prio_stall1", stall_cnt, 32'(stall_exp));
        chk("prio_drain", 32'(out_valid), 32'd0);
        ex_we = 1'b0;
        #1;
        chk("prio_ready2", 32'(in_ready), 32'd0);
        tick();
        stall_exp = 2;
        mem_we = 1'b0;
        #1;
        chk("prio_ready3", 32'(in_ready), 32'd1);
        tick();
        chk("prio_a", out_a, 32'h1003);
`endif
        chk("prio_pc", out_pc, 32'h104);
        chk("prio_stall", stall_cnt, 32'(stall_exp));
        ex_we = 1'b0;
        mem_we = 1'b0;

        // Load-use on rt.
        offer(32'h108, 5'd1, 5'd5);
        ex_we = 1'b1; ex_wa = 5'd5; ex_is_load = 1'b1; ex_wd = 32'h77;
        #1;
        chk("lu_ready", 32'(in_ready), 32'd0);
        tick();
        stall_exp++;
        chk("lu_stall", stall_cnt, 32'(stall_exp));
        ex_we = 1'b0; ex_is_load = 1'b0;
        mem_we = 1'b1; mem_wa = 5'd5; mem_wd = 32'hCAFE;
        #1;
`ifdef OPERAND_FORWARD_EN
        chk("lu_ready2", 32'(in_ready), 32'd1);
        tick();
        chk("lu_b", out_b, 32'hCAFE);
`else
        chk("lu_ready2", 32'(in_ready), 32'd0);
        tick();
        stall_exp++;
        mem_we = 1'b0;
        #1;
        tick();
        chk("lu_b", out_b, 32'h1005);
`endif
        chk("lu_a", out_a, 32'h1001);
        chk("lu_stall2", stall_cnt, 32'(stall_exp));
        mem_we = 1'b0;

        // EX writing r0 never hazards or forwards.
        offer(32'h10C, 5'd0, 5'd2);
        ex_we = 1'b1; ex_wa = 5'd0; ex_wd = 32'h55;
        #1;
        chk("z_ready", 32'(in_ready), 32'd1);
        tick();
        chk("z_a", out_a, 32'd0);
        chk("z_rs", 32'(out_rs), 32'd0);
        chk("z_stall", stall_cnt, 32'(stall_exp));
        ex_we = 1'b0;

        // Backpressure holds ID/EX stable.
        out_ready = 1'b0;
        offer(32'h110, 5'd6, 5'd7);
        chk("bp_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pc", out_pc, 32'h10C);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(in_ready), 32'd1);
        tick();
        chk("bp_pc2", out_pc, 32'h110);
        chk("bp_a", out_a, 32'h1006);
        chk("bp_rt", 32'(out_rt), 32'd7);

        // Flush kills ID/EX and the offered instruction.
        out_ready = 1'b0;
        flush = 1'b1;
        offer(32'h114, 5'd1, 5'd2);
        chk("fl_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_valid2", 32'(out_valid), 32'd0);
        chk("fl_pc", out_pc, 32'h110);

        // Reset mid-operation discards ID/EX.
        offer(32'h118, 5'd1, 5'd2);
        tick();
        chk("mr_valid0", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_pc", out_pc, 32'd0);
        chk("mr_stall", stall_cnt, 32'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
